mem_1_access: RTL

- Second memory stage. Consumes the m0_m1_* bundle (computed address, store data, destination, control) produced by the address stage.
- Performs the data-memory access through a req/ack handshake, stalls upstream while the access is outstanding, and presents a registered writeback bundle to the WB stage.
- Non-memory operations pass through with one cycle of latency.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_1_timeout_ctr.sv | 37 +++
 rtl/mem_1_access.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory pipeline stages.
//   - mem1_state_e   : access-stage FSM states (IDLE, WAIT)
//   - ADDR_W_DEF     : default data address width
//   - DATA_W_DEF     : default data word width
//   - REG_IDX_W      : register index width
//   - wb_ctrl_t      : control part of the writeback bundle
//   - WB_CTRL_BUBBLE : writeback control bubble (everything low)
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int REG_IDX_W  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem1_state_e;

    // The data word is carried separately so its width can follow DATA_W.
    typedef struct packed {
        logic                 oper;
        logic                 writereg;
        logic [REG_IDX_W-1:0] regdest;
        logic                 fault;
    } wb_ctrl_t;

    localparam wb_ctrl_t WB_CTRL_BUBBLE = '0;

endpackage

// File: rtl/mem_1_timeout_ctr.sv
// ---------------------------------------------------------------------------
// mem_1_timeout_ctr
// Counts WAIT cycles that pass without an acknowledge and flags expiry.
// Ports:
//   clock    in   clock
//   reset    in   asynchronous active-low reset
//   load_i   in   clear the count (access being issued)
//   inc_i    in   one more WAIT cycle without ack
//   expire_o out  this WAIT cycle is the last one allowed
// ---------------------------------------------------------------------------
module mem_1_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic load_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire_o = inc_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_1_access.sv
// ---------------------------------------------------------------------------
// mem_1_access
// Second memory stage: performs the data-memory access over a req/ack
// handshake, stalls the address stage while an access is outstanding and
// presents a registered writeback bundle. Non-memory ops pass through with
// one cycle of latency; misaligned memory ops complete at once with a fault.
// Optional feature macro: MEM1_TIMEOUT_EN (abandon an access after
// TIMEOUT_CYCLES WAIT cycles without ack, completing with a fault).
// Ports:
//   clock, reset        clock and asynchronous active-low reset
//   m0_m1_*             operation bundle from the address stage
//   m1_stall            upstream must hold its bundle while high
//   dmem_*              data memory request/ack interface
//   m1_wb_*, m1_fault   registered writeback bundle to the WB stage
// ---------------------------------------------------------------------------
module mem_1_access
    import mem_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 m0_m1_oper,
    input  logic                 m0_m1_readmem,
    input  logic                 m0_m1_writemem,
    input  logic [ADDR_W-1:0]    m0_m1_data_addr,
    input  logic [DATA_W-1:0]    m0_m1_regb,
    input  logic [REG_IDX_W-1:0] m0_m1_regdest,
    input  logic                 m0_m1_writereg,
    output logic                 m1_stall,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [ADDR_W-1:0]    dmem_addr,
    output logic [DATA_W-1:0]    dmem_wdata,
    input  logic [DATA_W-1:0]    dmem_rdata,
    input  logic                 dmem_ack,
    output logic                 m1_wb_oper,
    output logic                 m1_wb_writereg,
    output logic [REG_IDX_W-1:0] m1_wb_regdest,
    output logic [DATA_W-1:0]    m1_wb_data,
    output logic                 m1_fault
);

    if (TIMEOUT_CYCLES < 1) begin : gen_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    mem1_state_e          state_q, state_d;
    logic                 req_q, req_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [REG_IDX_W-1:0] regdest_q, regdest_d;
    logic                 writereg_q, writereg_d;
    logic                 load_q, load_d;
    wb_ctrl_t             wb_ctrl_q, wb_ctrl_d;
    logic [DATA_W-1:0]    wb_data_q, wb_data_d;
    logic                 tmo_expire;

    logic mem_op;
    logic aligned;
    assign mem_op  = m0_m1_readmem | m0_m1_writemem;
    assign aligned = (m0_m1_data_addr[1:0] == 2'b00);

`ifdef MEM1_TIMEOUT_EN
    logic tmo_load;
    logic tmo_inc;

    // Restart the count whenever an access is issued; count only unacked WAIT cycles.
    assign tmo_load = (state_q == IDLE) && m0_m1_oper && mem_op && aligned;
    assign tmo_inc  = (state_q == WAIT) && !dmem_ack;

    mem_1_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clock   (clock),
        .reset   (reset),
        .load_i  (tmo_load),
        .inc_i   (tmo_inc),
        .expire_o(tmo_expire)
    );
`else
    assign tmo_expire = 1'b0;
`endif

    // State, held request fields and the registered writeback bundle.
    // The asynchronous reset drops dmem_req at once, abandoning any access.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            regdest_q  <= '0;
            writereg_q <= 1'b0;
            load_q     <= 1'b0;
            wb_ctrl_q  <= WB_CTRL_BUBBLE;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            regdest_q  <= regdest_d;
            writereg_q <= writereg_d;
            load_q     <= load_d;
            wb_ctrl_q  <= wb_ctrl_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // Next state. The writeback bundle defaults to a bubble so that each op
    // produces exactly one single-cycle pulse. Inputs are ignored in WAIT and
    // the ack wins over a simultaneous timeout expiry.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        regdest_d  = regdest_q;
        writereg_d = writereg_q;
        load_d     = load_q;
        wb_ctrl_d  = WB_CTRL_BUBBLE;
        wb_data_d  = '0;

        case (state_q)
            IDLE: begin
                if (m0_m1_oper) begin
                    if (!mem_op) begin
                        wb_ctrl_d.oper     = 1'b1;
                        wb_ctrl_d.writereg = m0_m1_writereg;
                        wb_ctrl_d.regdest  = m0_m1_regdest;
                        wb_data_d          = m0_m1_regb;
                    end else if (!aligned) begin
                        wb_ctrl_d.oper    = 1'b1;
                        wb_ctrl_d.regdest = m0_m1_regdest;
                        wb_ctrl_d.fault   = 1'b1;
                    end else begin
                        state_d    = WAIT;
                        req_d      = 1'b1;
                        we_d       = m0_m1_writemem;
                        addr_d     = m0_m1_data_addr;
                        wdata_d    = m0_m1_regb;
                        regdest_d  = m0_m1_regdest;
                        writereg_d = m0_m1_writereg;
                        load_d     = m0_m1_readmem & ~m0_m1_writemem;
                    end
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    state_d           = IDLE;
                    req_d             = 1'b0;
                    wb_ctrl_d.oper    = 1'b1;
                    wb_ctrl_d.regdest = regdest_q;
                    if (load_q) begin
                        wb_ctrl_d.writereg = writereg_q;
                        wb_data_d          = dmem_rdata;
                    end
                end else if (tmo_expire) begin
                    state_d           = IDLE;
                    req_d             = 1'b0;
                    wb_ctrl_d.oper    = 1'b1;
                    wb_ctrl_d.regdest = regdest_q;
                    wb_ctrl_d.fault   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    assign m1_stall       = (state_q == WAIT);
    assign dmem_req       = req_q;
    assign dmem_we        = we_q;
    assign dmem_addr      = addr_q;
    assign dmem_wdata     = wdata_q;
    assign m1_wb_oper     = wb_ctrl_q.oper;
    assign m1_wb_writereg = wb_ctrl_q.writereg;
    assign m1_wb_regdest  = wb_ctrl_q.regdest;
    assign m1_wb_data     = wb_data_q;
    assign m1_fault       = wb_ctrl_q.fault;

endmodule
